// File: rtl/ifm_fetch_controller.sv
// IFM fetch controller: reads BEATS RAM words per vector and presents each vector over valid/ready.
// Optional HOLD-stall performance counter is enabled by defining IFM_FETCH_PERF_CNT_EN.
module ifm_fetch_controller #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int BEATS  = 4,
    parameter int CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [ADDR_W-1:0]       base_addr,
    input  logic [CNT_W-1:0]        num_vectors,
    output logic                    rd_en,
    output logic [ADDR_W-1:0]       rd_addr,
    input  logic [DATA_W-1:0]       rd_data,
    output logic [BEATS*DATA_W-1:0] vec_data,
    output logic                    vec_valid,
    input  logic                    vec_ready,
    output logic                    busy,
`ifdef IFM_FETCH_PERF_CNT_EN
    output logic [31:0]             stall_cycles,
`endif
    output logic                    done
);

    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_DRAIN = 3'd2,
        ST_HOLD  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t                  state_r;
    state_t                  state_s;
    logic [BEAT_W-1:0]       beat_cnt_r;
    logic [BEAT_W-1:0]       cap_idx_r;
    logic                    cap_vld_r;
    logic [CNT_W-1:0]        rem_r;
    logic [ADDR_W-1:0]       rd_addr_r;
    logic                    rd_en_r;
    logic [BEATS*DATA_W-1:0] vec_data_r;
    logic                    vec_valid_r;
    logic                    busy_r;
    logic                    done_r;
    logic                    start_acc_s;
    logic                    hs_s;

    assign start_acc_s = (state_r == ST_IDLE) && start;
    assign hs_s        = (state_r == ST_HOLD) && vec_ready;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    if (num_vectors != {CNT_W{1'b0}}) begin
                        state_s = ST_FETCH;
                    end else begin
                        state_s = ST_DONE;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (beat_cnt_r == LAST_BEAT) begin
                    state_s = ST_DRAIN;
                end else begin
                    state_s = ST_FETCH;
                end
            end
            ST_DRAIN: state_s = ST_HOLD;
            ST_HOLD: begin
                if (vec_ready) begin
                    if (rem_r == CNT_W'(1)) begin
                        state_s = ST_DONE;
                    end else begin
                        state_s = ST_FETCH;
                    end
                end else begin
                    state_s = ST_HOLD;
                end
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // Address, counters and beat capture; read data lands one cycle after its issue
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_addr_r  <= {ADDR_W{1'b0}};
            beat_cnt_r <= {BEAT_W{1'b0}};
            cap_idx_r  <= {BEAT_W{1'b0}};
            cap_vld_r  <= 1'b0;
            rem_r      <= {CNT_W{1'b0}};
            vec_data_r <= {(BEATS*DATA_W){1'b0}};
        end else begin
            if (start_acc_s) begin
                rd_addr_r <= base_addr;
            end else if (state_r == ST_FETCH) begin
                rd_addr_r <= rd_addr_r + ADDR_W'(1);
            end

            if (state_r == ST_FETCH && beat_cnt_r != LAST_BEAT) begin
                beat_cnt_r <= beat_cnt_r + BEAT_W'(1);
            end else begin
                beat_cnt_r <= {BEAT_W{1'b0}};
            end

            cap_vld_r <= (state_r == ST_FETCH);
            cap_idx_r <= beat_cnt_r;
            if (cap_vld_r) begin
                vec_data_r[cap_idx_r*DATA_W +: DATA_W] <= rd_data;
            end

            if (start_acc_s) begin
                rem_r <= num_vectors;
            end else if (hs_s) begin
                rem_r <= rem_r - CNT_W'(1);
            end
        end
    end

    // Registered control outputs derived from the upcoming state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_en_r     <= 1'b0;
            vec_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            rd_en_r     <= (state_s == ST_FETCH);
            vec_valid_r <= (state_s == ST_HOLD);
            busy_r      <= (state_s != ST_IDLE);
            done_r      <= (state_s == ST_DONE);
        end
    end

`ifdef IFM_FETCH_PERF_CNT_EN
    logic [31:0] stall_r;

    // Saturating count of HOLD cycles without vec_ready
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_r <= 32'd0;
        end else if (start_acc_s) begin
            stall_r <= 32'd0;
        end else if (state_r == ST_HOLD && !vec_ready && stall_r != 32'hFFFF_FFFF) begin
            stall_r <= stall_r + 32'd1;
        end
    end

    assign stall_cycles = stall_r;
`endif

    assign rd_en     = rd_en_r;
    assign rd_addr   = rd_addr_r;
    assign vec_data  = vec_data_r;
    assign vec_valid = vec_valid_r;
    assign busy      = busy_r;
    assign done      = done_r;

endmodule

// File: tb/tb_ifm_fetch_controller.sv
// Scoreboard bench for ifm_fetch_controller: expected addresses and vectors are queued at start
// and compared as the DUT issues reads and completes handshakes.
module tb_ifm_fetch_controller;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int BEATS  = 4;
    localparam int CNT_W  = 16;
    localparam int VW     = BEATS * DATA_W;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [CNT_W-1:0]  num_vectors;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic [VW-1:0]     vec_data;
    logic              vec_valid;
    logic              vec_ready;
    logic              busy;
    logic              done;
`ifdef IFM_FETCH_PERF_CNT_EN
    logic [31:0]       stall_cycles;
`endif

    ifm_fetch_controller #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BEATS(BEATS), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .num_vectors(num_vectors), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .vec_data(vec_data), .vec_valid(vec_valid), .vec_ready(vec_ready), .busy(busy),
`ifdef IFM_FETCH_PERF_CNT_EN
        .stall_cycles(stall_cycles),
`endif
        .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] ram(input logic [ADDR_W-1:0] a);
        return a + 32'h0000_0090;
    endfunction

    // RAM model: one-cycle read latency
    always @(posedge clk) begin
        if (rd_en) rd_data <= ram(rd_addr);
    end

    logic [ADDR_W-1:0] exp_addr_q[$];
    logic [VW-1:0]     exp_vec_q[$];
    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0, hold_cnt = 0, stall_len = 0, t_rd = 0, t_hs = 0;
    int n_hs = 0, n_done = 0, n_valid_rise = 0;
    bit ready_idle = 1'b0;
    bit zero_mode = 1'b0;
    logic prev_valid = 1'b0, prev_rd_en = 1'b0;
    logic [VW-1:0] prev_vec = '0;

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Monitor and vec_ready driver, all on the falling edge
    initial begin
        vec_ready = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                hold_cnt = 0; prev_valid = 1'b0; prev_rd_en = 1'b0; vec_ready = 1'b0;
            end else begin
                if (rd_en) begin
                    check("rd_expected", 128'(exp_addr_q.size() != 0), 128'(1));
                    if (exp_addr_q.size() != 0) check("rd_addr", 128'(rd_addr), 128'(exp_addr_q.pop_front()));
                    if (!prev_rd_en) t_rd = cyc;
                end
                if (vec_valid && !prev_valid) begin
                    n_valid_rise++;
                    check("valid_latency", 128'(cyc - t_rd), 128'(BEATS + 1));
                end
                if (vec_valid && prev_valid) check("vec_stable", 128'(vec_data), 128'(prev_vec));
                if (done) begin
                    n_done++;
                    if (!zero_mode) check("done_after_hs", 128'(cyc - t_hs), 128'(1));
                end
                if (vec_valid) begin
                    vec_ready = (hold_cnt >= stall_len);
                    hold_cnt++;
                end else begin
                    hold_cnt = 0;
                    vec_ready = ready_idle;
                end
                if (vec_valid && vec_ready) begin
                    n_hs++;
                    t_hs = cyc;
                    check("vec_expected", 128'(exp_vec_q.size() != 0), 128'(1));
                    if (exp_vec_q.size() != 0) check("vec_data", 128'(vec_data), 128'(exp_vec_q.pop_front()));
                end
                prev_valid = vec_valid; prev_rd_en = rd_en; prev_vec = vec_data;
            end
        end
    end

    task automatic do_start(input logic [ADDR_W-1:0] base, input int num, input bit push);
        logic [VW-1:0]     v;
        logic [ADDR_W-1:0] a;
        start = 1'b1; base_addr = base; num_vectors = CNT_W'(num);
        if (push) begin
            for (int n = 0; n < num; n++) begin
                v = '0;
                for (int k = 0; k < BEATS; k++) begin
                    a = base + ADDR_W'(n * BEATS + k);
                    exp_addr_q.push_back(a);
                    v[k*DATA_W +: DATA_W] = ram(a);
                end
                exp_vec_q.push_back(v);
            end
        end
        @(negedge clk);
        start = 1'b0; base_addr = 32'hDEAD_0000; num_vectors = 16'd9;
    endtask

    task automatic wait_done(input string tag, input int budget, output int lat);
        lat = 0;
        while (!done && lat < budget) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_done_seen"}, 128'(done), 128'(1));
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int i = 0;
        while (!vec_valid && i < budget) begin
            @(negedge clk);
            i++;
        end
        check({tag, "_valid_seen"}, 128'(vec_valid), 128'(1));
    endtask

    initial begin
        int lat, hs0, d0, vr0;
        rst_n = 1'b0; start = 1'b0; base_addr = '0; num_vectors = '0;
        repeat (3) @(negedge clk);
        check("rst_rd_en", 128'(rd_en), 128'(0));
        check("rst_rd_addr", 128'(rd_addr), 128'(0));
        check("rst_vec_data", 128'(vec_data), 128'(0));
        check("rst_vec_valid", 128'(vec_valid), 128'(0));
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_done", 128'(done), 128'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // Single vector, vec_ready tied high
        ready_idle = 1'b1; stall_len = 0;
        do_start(32'h10, 1, 1'b1);
        check("t1_busy", 128'(busy), 128'(1));
        wait_valid("t1", 20);
        check("t1_vec_const", 128'(vec_data), 128'h000000A3_000000A2_000000A1_000000A0);
        wait_done("t1", 20, lat);
        @(negedge clk);
        check("t1_busy_after", 128'(busy), 128'(0));
        check("t1_done_pulse", 128'(done), 128'(0));

        // Three vectors with 7 stall cycles each
        ready_idle = 1'b0; stall_len = 7;
        hs0 = n_hs; d0 = n_done;
        do_start(32'h0, 3, 1'b1);
        wait_done("t2", 200, lat);
        @(negedge clk);
        check("t2_handshakes", 128'(n_hs - hs0), 128'(3));
        check("t2_done_count", 128'(n_done - d0), 128'(1));
        check("t2_addr_q_empty", 128'(exp_addr_q.size()), 128'(0));
`ifdef IFM_FETCH_PERF_CNT_EN
        check("t2_stall_cycles", 128'(stall_cycles), 128'(21));
        repeat (3) @(negedge clk);
        check("t2_stall_held", 128'(stall_cycles), 128'(21));
`endif

        // Zero vectors
        zero_mode = 1'b1; vr0 = n_valid_rise;
        do_start(32'h20, 0, 1'b1);
        wait_done("t3", 5, lat);
        check("t3_done_lat", 128'(lat), 128'(0));
        @(negedge clk);
        zero_mode = 1'b0;
        check("t3_no_valid", 128'(n_valid_rise - vr0), 128'(0));
        check("t3_busy_after", 128'(busy), 128'(0));

        // Address wrap
        stall_len = 2;
        do_start(32'hFFFF_FFFE, 1, 1'b1);
        wait_done("t4", 50, lat);
        @(negedge clk);

        // Start while busy is ignored; start during done is ignored; start after done accepted
        stall_len = 3;
        do_start(32'h0, 2, 1'b1);
        repeat (4) @(negedge clk);
        start = 1'b1; base_addr = 32'h100; num_vectors = 16'd5;
        @(negedge clk);
        start = 1'b0;
        wait_done("t5", 100, lat);
        start = 1'b1; base_addr = 32'h200; num_vectors = 16'd1;
        @(negedge clk);
        start = 1'b0;
        check("t5_idle_busy", 128'(busy), 128'(0));
        do_start(32'h300, 1, 1'b1);
        wait_done("t5b", 50, lat);
        @(negedge clk);
        check("t5_addr_q_empty", 128'(exp_addr_q.size()), 128'(0));
        check("t5_vec_q_empty", 128'(exp_vec_q.size()), 128'(0));

        // Reset while a vector is held
        stall_len = 1000;
        do_start(32'h40, 1, 1'b1);
        wait_valid("t6", 20);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_valid", 128'(vec_valid), 128'(0));
        check("t6_rst_busy", 128'(busy), 128'(0));
        check("t6_rst_rd_en", 128'(rd_en), 128'(0));
        check("t6_rst_done", 128'(done), 128'(0));
        exp_addr_q.delete();
        exp_vec_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        stall_len = 0;
        vr0 = n_valid_rise;
        repeat (10) @(negedge clk);
        check("t6_no_valid", 128'(n_valid_rise - vr0), 128'(0));
        check("t6_idle_busy", 128'(busy), 128'(0));
        do_start(32'h50, 1, 1'b1);
        wait_done("t6b", 30, lat);
        @(negedge clk);
        check("t6_vec_q_empty", 128'(exp_vec_q.size()), 128'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
